prog_loader: RTL



---
 rtl/mas_pkg.sv | 17 +
 rtl/prog_buf.sv | 31 +++
 rtl/prog_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mas_pkg.sv
// Shared types for the MASpcsr program loader: FSM state encoding and instruction-word constants.
// Imported by the loader top and its word buffer.
package mas_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] PAD_WORD = 16'h0000;

  typedef enum logic [2:0] {
    IDLE,
    RX_HI,
    RX_LO,
    PAD,
    BURST,
    DONE
  } ld_state_e;

endpackage

// File: rtl/prog_buf.sv
// Program word store: DEPTH x 16 simple dual-port RAM, one synchronous write and one synchronous read port.
// Read data appears the cycle after rd_en; contents are not reset, and no backpressure applies.
module prog_buf
  import mas_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_dat,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_dat
);

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [INSTR_W-1:0] rd_dat_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_dat;
  end

  always_ff @(posedge clk) begin
    if (rd_en) rd_dat_q <= mem_q[rd_addr];
  end

  assign rd_dat = rd_dat_q;

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: buffers an N-word frame, then bursts a pad word plus N words with pr high.
// pr rises the edge after the last byte; in_ready depends on state only, so the source holds bytes while we burst.
module prog_loader
  import mas_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rstz,
  input  logic               en,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               pr,
  output logic [INSTR_W-1:0] instr_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [8:0] DEPTH9 = 9'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [AW-1:0]     nm1_q, nm1_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [7:0]        hi_q, hi_d;
  logic              pr_q, pr_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              take;
  logic              wr_en;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [INSTR_W-1:0] rd_dat;

  assign in_ready = rstz & en & (state_q inside {IDLE, RX_HI, RX_LO});
  assign take     = in_valid & in_ready;
  assign busy     = (state_q != IDLE);
  assign pr       = pr_q;
  assign done     = done_q;
  assign err      = err_q;

  // Word k+1 is fetched while word k is on the bus; PAD fetches word 0.
  assign rd_en   = en & ((state_q == PAD) | (state_q == BURST));
  assign rd_addr = (state_q == PAD) ? '0 : rptr_q + AW'(1);

  always_comb begin
    instr_out = '0;
    case (state_q)
      PAD:     instr_out = PAD_WORD;
      BURST:   instr_out = rd_dat;
      default: instr_out = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    nm1_d   = nm1_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    hi_d    = hi_q;
    pr_d    = pr_q;
    done_d  = done_q;
    err_d   = err_q;
    wr_en   = 1'b0;

    if (en) begin
      done_d = 1'b0;
      err_d  = 1'b0;
      case (state_q)
        IDLE: begin
          if (take && in_data != 8'd0) begin
            if ({1'b0, in_data} > DEPTH9) begin
              err_d = 1'b1;
            end else begin
              nm1_d   = AW'(in_data - 8'd1);
              wptr_d  = '0;
              state_d = RX_HI;
            end
          end
        end
        RX_HI: begin
          if (take) begin
            hi_d    = in_data;
            state_d = RX_LO;
          end
        end
        RX_LO: begin
          if (take) begin
            wr_en = 1'b1;
            if (wptr_q == nm1_q) begin
              pr_d    = 1'b1;
              state_d = PAD;
            end else begin
              wptr_d  = wptr_q + AW'(1);
              state_d = RX_HI;
            end
          end
        end
        PAD: begin
          rptr_d  = '0;
          state_d = BURST;
        end
        BURST: begin
          if (rptr_q == nm1_q) begin
            pr_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            rptr_d = rptr_q + AW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          pr_d    = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= IDLE;
      nm1_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      hi_q    <= '0;
      pr_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      nm1_q   <= nm1_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      hi_q    <= hi_d;
      pr_q    <= pr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  prog_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q),
    .wr_dat  ({hi_q, in_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

endmodule
